// File: rtl/e203_subsys_pllctl_pkg.sv
// Shared types and defaults for the PLL control sequencer: state encoding,
// registered control-output bundle and the reset divider values.
package e203_subsys_pllctl_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_OFF   = 3'd1,
        ST_SLEEP = 3'd2,
        ST_SWOUT = 3'd3,
        ST_RESET = 3'd4,
        ST_LOCK  = 3'd5
    } state_t;

    localparam logic [7:0] M_RST_DEF  = 8'd32;
    localparam logic [4:0] N_RST_DEF  = 5'd1;
    localparam logic [1:0] OD_RST_DEF = 2'd1;

    typedef struct packed {
        logic asleep;
        logic reset;
        logic sel;
        logic locked;
        logic ack;
        logic busy;
    } ctl_t;

    // Control outputs as a pure function of state; registered from next state
    // so every output changes on the same edge as the state itself.
    function automatic ctl_t decode(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            ST_RUN:   begin c.sel = 1'b1; c.locked = 1'b1; end
            ST_OFF:   begin c.asleep = 1'b1; c.reset = 1'b1; end
            ST_SLEEP: begin c.asleep = 1'b1; c.reset = 1'b1; c.ack = 1'b1; end
            ST_SWOUT: begin c.busy = 1'b1; end
            ST_RESET: begin c.reset = 1'b1; c.busy = 1'b1; end
            ST_LOCK:  begin c.busy = 1'b1; end
            default:  begin c.reset = 1'b1; c.busy = 1'b1; end
        endcase
        return c;
    endfunction

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/e203_subsys_pllctl.sv
// PLL control sequencer: moves the clock mux off the PLL, resets it with new
// divider settings, waits for lock and switches back; also handles sleep/bypass.
module e203_subsys_pllctl
    import e203_subsys_pllctl_pkg::*;
#(
    parameter int         SEL_CYCLES  = 4,
    parameter int         RST_CYCLES  = 16,
    parameter int         LOCK_CYCLES = 1024,
    parameter logic [7:0] M_RST       = M_RST_DEF,
    parameter logic [4:0] N_RST       = N_RST_DEF,
    parameter logic [1:0] OD_RST      = OD_RST_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_m,
    input  logic [4:0] cfg_n,
    input  logic [1:0] cfg_od,
    input  logic       cfg_bypass,
    input  logic       sleep_req,
    output logic       sleep_ack,
    output logic       pll_asleep,
    output logic       pll_RESET,
    output logic [7:0] pll_M,
    output logic [4:0] pll_N,
    output logic [1:0] pll_OD,
    output logic       pll_sel,
    output logic       pll_locked,
    output logic       busy
);

    localparam int MAX_CYCLES = max3(SEL_CYCLES, RST_CYCLES, LOCK_CYCLES);
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] SEL_LD  = CW'(SEL_CYCLES - 1);
    localparam logic [CW-1:0] RST_LD  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LD = CW'(LOCK_CYCLES - 1);

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic          byp, next_byp;
    logic          pend, next_pend;
    ctl_t          ctl;
    logic          accept;
    logic          cnt_done;

    function automatic logic [CW-1:0] load_val(state_t s);
        case (s)
            ST_SWOUT: return SEL_LD;
            ST_RESET: return RST_LD;
            ST_LOCK:  return LOCK_LD;
            default:  return '0;
        endcase
    endfunction

    assign cfg_ready = ((state == ST_RUN) || (state == ST_OFF)) && !sleep_req;
    assign accept    = cfg_valid && cfg_ready;
    assign cnt_done  = (cnt == '0);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned -- otherwise synthesis infers a latch.
        next_state = state;
        next_byp   = accept ? cfg_bypass : byp;
        next_pend  = pend;
        case (state)
            ST_RUN: begin
                if (sleep_req) begin
                    next_state = ST_SWOUT;
                    next_pend  = 1'b1;
                end else if (accept) begin
                    next_state = ST_SWOUT;
                end
            end
            ST_OFF: begin
                if (sleep_req)                 next_state = ST_SLEEP;
                else if (accept && !cfg_bypass) next_state = ST_RESET;
            end
            ST_SLEEP: begin
                if (!sleep_req) next_state = byp ? ST_OFF : ST_RESET;
            end
            ST_SWOUT: begin
                if (cnt_done) begin
                    next_pend = 1'b0;
                    if (pend)     next_state = ST_SLEEP;
                    else if (byp) next_state = ST_OFF;
                    else          next_state = ST_RESET;
                end
            end
            ST_RESET: if (cnt_done) next_state = ST_LOCK;
            ST_LOCK:  if (cnt_done) next_state = ST_RUN;
            default:  next_state = ST_RESET;
        endcase

        if (next_state != state) next_cnt = load_val(next_state);
        else if (!cnt_done)      next_cnt = cnt - 1'b1;
        else                     next_cnt = cnt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RESET;
            cnt   <= RST_LD;
            byp   <= 1'b0;
            pend  <= 1'b0;
            ctl   <= decode(ST_RESET);
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            byp   <= next_byp;
            pend  <= next_pend;
            ctl   <= decode(next_state);
        end
    end

    // Dividers only move on capture, which happens in RUN (mux then leaves the
    // PLL) or OFF (PLL already held in reset), so the PLL never sees a glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_M  <= M_RST;
            pll_N  <= N_RST;
            pll_OD <= OD_RST;
        end else if (accept) begin
            pll_M  <= cfg_m;
            pll_N  <= cfg_n;
            pll_OD <= cfg_od;
        end
    end

    assign pll_asleep = ctl.asleep;
    assign pll_RESET  = ctl.reset;
    assign pll_sel    = ctl.sel;
    assign pll_locked = ctl.locked;
    assign sleep_ack  = ctl.ack;
    assign busy       = ctl.busy;

endmodule
